// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes and default widths.
package hazard_pkg;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W_DEF      = 16;

  // RUN: normal flow; DRAIN: a wrong-path fetch is still outstanding in imem.
  localparam logic [0:0] STATE_RUN   = 1'b0;
  localparam logic [0:0] STATE_DRAIN = 1'b1;
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: the ID instruction reads the register a load in EX is about to write.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_memRead,
  input  logic                  ex_writeEnable,
  input  logic [REG_ADDR_W-1:0] ex_des_register,
  output logic                  hazard
);
  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 & (id_rs1 == ex_des_register);
  assign rs2_match = id_uses_rs2 & (id_rs2 == ex_des_register);
  // x0 is never written, so a load targeting it cannot create a dependency.
  assign hazard = ex_memRead & ex_writeEnable & (ex_des_register != '0) & (rs1_match | rs2_match);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hold/flush controller: prioritised stall/flush decisions, wrong-path drain FSM
// and saturating stall/flush statistics.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  imem_busywait,
  input  logic                  dmem_busywait,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_memRead,
  input  logic                  ex_writeEnable,
  input  logic [REG_ADDR_W-1:0] ex_des_register,
  input  logic                  ex_redirect,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  idex_hold,
  output logic                  exmem_hold,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_flush,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);
  logic [0:0] state;
  logic [0:0] state_next;
  logic       load_use;
  logic       redirect_accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_memRead     (ex_memRead),
    .ex_writeEnable (ex_writeEnable),
    .ex_des_register(ex_des_register),
    .hazard         (load_use)
  );

  always_comb begin
    pc_hold         = 1'b0;
    ifid_hold       = 1'b0;
    idex_hold       = 1'b0;
    exmem_hold      = 1'b0;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    memwb_flush     = 1'b0;
    redirect_accept = 1'b0;
    state_next      = state;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      state_next  = STATE_RUN;
    end else if (dmem_busywait) begin
      // Freeze everything up to EX; a held redirect is re-presented once dmem completes.
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_hold   = 1'b1;
      exmem_hold  = 1'b1;
      memwb_flush = 1'b1;
      if (state == STATE_DRAIN && !imem_busywait) state_next = STATE_RUN;
    end else if (ex_redirect) begin
      ifid_flush      = 1'b1;
      idex_flush      = 1'b1;
      redirect_accept = 1'b1;
      state_next      = imem_busywait ? STATE_DRAIN : STATE_RUN;
    end else if (state == STATE_DRAIN) begin
      // The wrong-path word returned in the exit cycle is discarded by the flush.
      pc_hold    = 1'b1;
      ifid_flush = 1'b1;
      if (!imem_busywait) state_next = STATE_RUN;
    end else if (load_use) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_flush = 1'b1;
    end else if (imem_busywait) begin
      pc_hold    = 1'b1;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= STATE_RUN;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_next;
      if (pc_hold) stall_cycles <= sat_inc(stall_cycles);
      if (redirect_accept) flush_count <= sat_inc(flush_count);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, imem_busywait, dmem_busywait;
  logic [4:0] id_rs1, id_rs2, ex_des_register;
  logic       id_uses_rs1, id_uses_rs2, ex_memRead, ex_writeEnable, ex_redirect;

  logic pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, memwb_flush;
  logic [15:0] stall_cycles, flush_count;
  logic pc_hold_s, ifid_hold_s, idex_hold_s, exmem_hold_s, ifid_flush_s, idex_flush_s, memwb_flush_s;
  logic [3:0] stall_cycles_s, flush_count_s;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_drain;
  int m_stall, m_flush, m_stall_s, m_flush_s;
  bit e_pc, e_ifid_h, e_idex_h, e_exmem_h, e_ifid_f, e_idex_f, e_memwb_f, e_accept;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memRead(ex_memRead), .ex_writeEnable(ex_writeEnable), .ex_des_register(ex_des_register),
    .ex_redirect(ex_redirect), .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
    .exmem_hold(exmem_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memRead(ex_memRead), .ex_writeEnable(ex_writeEnable), .ex_des_register(ex_des_register),
    .ex_redirect(ex_redirect), .pc_hold(pc_hold_s), .ifid_hold(ifid_hold_s), .idex_hold(idex_hold_s),
    .exmem_hold(exmem_hold_s), .ifid_flush(ifid_flush_s), .idex_flush(idex_flush_s),
    .memwb_flush(memwb_flush_s), .stall_cycles(stall_cycles_s), .flush_count(flush_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit load_use_model();
    bit reads_dest;
    reads_dest = 1'b0;
    if (id_uses_rs1 && id_rs1 == ex_des_register) reads_dest = 1'b1;
    if (id_uses_rs2 && id_rs2 == ex_des_register) reads_dest = 1'b1;
    return ex_memRead && ex_writeEnable && ex_des_register != 5'd0 && reads_dest;
  endfunction

  task automatic model_outputs();
    {e_pc, e_ifid_h, e_idex_h, e_exmem_h, e_ifid_f, e_idex_f, e_memwb_f, e_accept} = '0;
    if (reset) begin
      e_ifid_f = 1; e_idex_f = 1; e_memwb_f = 1;
    end else if (dmem_busywait) begin
      e_pc = 1; e_ifid_h = 1; e_idex_h = 1; e_exmem_h = 1; e_memwb_f = 1;
    end else if (ex_redirect) begin
      e_ifid_f = 1; e_idex_f = 1; e_accept = 1;
    end else if (m_drain) begin
      e_pc = 1; e_ifid_f = 1;
    end else if (load_use_model()) begin
      e_pc = 1; e_ifid_h = 1; e_idex_f = 1;
    end else if (imem_busywait) begin
      e_pc = 1; e_ifid_f = 1;
    end
  endtask

  // Called right after a negedge with inputs already applied; returns at the next negedge.
  task automatic step(input string tag);
    model_outputs();
    #2;
    chk({tag, ".pc_hold"}, pc_hold, e_pc);
    chk({tag, ".ifid_hold"}, ifid_hold, e_ifid_h);
    chk({tag, ".idex_hold"}, idex_hold, e_idex_h);
    chk({tag, ".exmem_hold"}, exmem_hold, e_exmem_h);
    chk({tag, ".ifid_flush"}, ifid_flush, e_ifid_f);
    chk({tag, ".idex_flush"}, idex_flush, e_idex_f);
    chk({tag, ".memwb_flush"}, memwb_flush, e_memwb_f);
    chk({tag, ".sat_ctrl"}, {pc_hold_s, ifid_flush_s, idex_flush_s},
        {pc_hold, ifid_flush, idex_flush});
    @(posedge clock);
    if (reset) begin
      m_drain = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else begin
      if (e_pc) begin
        m_stall   = (m_stall < 65535) ? m_stall + 1 : m_stall;
        m_stall_s = (m_stall_s < 15) ? m_stall_s + 1 : m_stall_s;
      end
      if (e_accept) begin
        m_flush   = (m_flush < 65535) ? m_flush + 1 : m_flush;
        m_flush_s = (m_flush_s < 15) ? m_flush_s + 1 : m_flush_s;
      end
      if (dmem_busywait) m_drain = m_drain && imem_busywait;
      else if (ex_redirect) m_drain = imem_busywait;
      else if (m_drain) m_drain = imem_busywait;
    end
    #1;
    chk({tag, ".stall_cycles"}, stall_cycles, m_stall);
    chk({tag, ".flush_count"}, flush_count, m_flush);
    chk({tag, ".stall_cycles_sat"}, stall_cycles_s, m_stall_s);
    chk({tag, ".flush_count_sat"}, flush_count_s, m_flush_s);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    imem_busywait = 0; dmem_busywait = 0; ex_redirect = 0;
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_memRead = 0; ex_writeEnable = 0; ex_des_register = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_drain = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    @(negedge clock);

    // Reset for two cycles
    step("reset0");
    step("reset1");
    reset = 0;
    step("post_reset");
    chk("reset_stall_zero", stall_cycles, 32'd0);

    // Load-use: lw x5 in EX, add x6,x5,x7 in ID
    ex_memRead = 1; ex_writeEnable = 1; ex_des_register = 5'd5;
    id_rs1 = 5'd5; id_rs2 = 5'd7; id_uses_rs1 = 1; id_uses_rs2 = 1;
    step("load_use");
    ex_memRead = 0; ex_writeEnable = 0; ex_des_register = 5'd0;
    step("load_use_after");
    chk("load_use_stall_count", stall_cycles, 32'd1);

    // Load to x0 followed by a read of x0
    ex_memRead = 1; ex_writeEnable = 1; ex_des_register = 5'd0;
    id_rs1 = 5'd0; id_uses_rs1 = 1; id_rs2 = 5'd0; id_uses_rs2 = 1;
    step("x0_load");
    idle_inputs();

    // Redirect with imem busy, drain until imem returns
    ex_redirect = 1; imem_busywait = 1;
    step("redir_busy");
    ex_redirect = 0;
    step("drain1");
    step("drain2");
    imem_busywait = 0;
    step("drain_exit");
    step("drain_done");
    chk("redir_flush_count", flush_count, 32'd1);

    // dmem stall while EX holds a redirect
    ex_redirect = 1; dmem_busywait = 1;
    for (int i = 0; i < 5; i++) step("dmem_stall");
    dmem_busywait = 0;
    step("dmem_redirect_accept");
    ex_redirect = 0;
    step("dmem_after");
    chk("dmem_flush_count", flush_count, 32'd2);

    // Saturation of the narrow counter
    reset = 1;
    step("sat_reset");
    reset = 0;
    imem_busywait = 1;
    for (int i = 0; i < 20; i++) step("sat_busy");
    imem_busywait = 0;
    step("sat_end");
    chk("sat_stall_narrow", stall_cycles_s, 32'd15);
    chk("sat_stall_wide", stall_cycles, 32'd20);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset           = ($urandom_range(0, 39) == 0);
      imem_busywait   = ($urandom_range(0, 9) < 4);
      dmem_busywait   = ($urandom_range(0, 9) < 2);
      ex_redirect     = ($urandom_range(0, 9) < 2);
      ex_memRead      = $urandom_range(0, 1);
      ex_writeEnable  = ($urandom_range(0, 3) != 0);
      ex_des_register = 5'($urandom_range(0, 3));
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_uses_rs1     = $urandom_range(0, 1);
      id_uses_rs2     = $urandom_range(0, 1);
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
